// File: rtl/residual_fusion_unit.sv
// Residual fusion: streams main-path P1 pixels and shortcut pixels,
// adds them per lane, rounds/shifts, optional ReLU, saturates, writes out.
module residual_fusion_unit #(
  parameter int DATA_W    = 8,
  parameter int IN_CH     = 8,
  parameter int IMG_W     = 5,
  parameter int IMG_H     = 4,
  parameter int FM_ADDR_W = 10,
  parameter int SHIFT     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clk_en,
  input  logic                    i_start,
  input  logic                    i_relu_en,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [FM_ADDR_W-1:0]    o_main_rd_addr,
  input  logic [IN_CH*DATA_W-1:0] i_main_rd_data_flat,
  output logic                    o_sc_rd_en,
  output logic [FM_ADDR_W-1:0]    o_sc_rd_addr,
  input  logic [IN_CH*DATA_W-1:0] i_sc_rd_data_flat,
  output logic                    o_out_wr_en,
  output logic [FM_ADDR_W-1:0]    o_out_wr_addr,
  output logic [IN_CH*DATA_W-1:0] o_out_wr_data_flat
);

  localparam int N  = IMG_W * IMG_H;
  localparam int SW = DATA_W + 2;
  localparam int PW = IN_CH * DATA_W;

  localparam logic [FM_ADDR_W-1:0] LAST =
    FM_ADDR_W'(N - 1);
  localparam logic signed [SW-1:0] RND =
    SW'((2 ** SHIFT) / 2);
  localparam logic signed [SW-1:0] MAXV =
    SW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV =
    -MAXV - SW'(1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   relu_q, relu_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [FM_ADDR_W-1:0]   addr_q, addr_d;
  logic                   rd_en_q, rd_en_d;
  logic                   vld_q, vld_d;
  logic [FM_ADDR_W-1:0]   vaddr_q, vaddr_d;
  logic                   wr_en_q, wr_en_d;
  logic [FM_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [PW-1:0]          wr_data_q, wr_data_d;
  logic [PW-1:0]          fused;

  // Per-lane add, round-shift, ReLU and saturate of the returning data.
  always_comb begin
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic signed [SW-1:0]  s;
    logic signed [SW-1:0]  r;
    fused = '0;
    for (int i = 0; i < IN_CH; i++) begin
      a = i_main_rd_data_flat[(i+1)*DATA_W-1 -: DATA_W];
      b = i_sc_rd_data_flat[(i+1)*DATA_W-1 -: DATA_W];
      s = {{2{a[DATA_W-1]}}, a}
        + {{2{b[DATA_W-1]}}, b};
      s = s + RND;
      r = s >>> SHIFT;
      if (relu_q && (r < 0)) r = '0;
      if (r > MAXV) r = MAXV;
      if (r < MINV) r = MINV;
      fused[(i+1)*DATA_W-1 -: DATA_W] = r[DATA_W-1:0];
    end
  end

  // Next-state: run FSM, address issue and read/write pipeline.
  always_comb begin
    state_d   = state_q;
    relu_d    = relu_q;
    busy_d    = busy_q;
    done_d    = done_q;
    addr_d    = addr_q;
    rd_en_d   = rd_en_q;
    vld_d     = rd_en_q;
    vaddr_d   = addr_q;
    wr_en_d   = vld_q;
    wr_addr_d = vld_q ? vaddr_q : wr_addr_q;
    wr_data_d = vld_q ? fused : wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = READ;
          relu_d  = i_relu_en;
          addr_d  = '0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        if (addr_q == LAST) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
        end else begin
          addr_d = addr_q + FM_ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (wr_en_q && (wr_addr_q == LAST)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; all hold while the global enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      relu_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      vld_q     <= 1'b0;
      vaddr_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (i_clk_en) begin
      state_q   <= state_d;
      relu_q    <= relu_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      vld_q     <= vld_d;
      vaddr_q   <= vaddr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_main_rd_addr     = addr_q;
  assign o_sc_rd_en         = rd_en_q;
  assign o_sc_rd_addr       = addr_q;
  assign o_out_wr_en        = wr_en_q;
  assign o_out_wr_addr      = wr_addr_q;
  assign o_out_wr_data_flat = wr_data_q;

endmodule

// File: tb/tb_residual_fusion_unit.sv
// Bench for residual_fusion_unit: SHIFT=1 and SHIFT=0 instances,
// BRAM models, scoreboard of expected writes per instance.
module tb_residual_fusion_unit;

  localparam int N  = 20;
  localparam int AW = 10;
  localparam int PW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;
  logic start = 1'b0;
  logic relu_en = 1'b0;

  logic          busy0, done0, scen0, wren0;
  logic [AW-1:0] maddr0, scaddr0, wraddr0;
  logic [PW-1:0] md0, sd0, wrdata0;
  logic          busy1, done1, scen1, wren1;
  logic [AW-1:0] maddr1, scaddr1, wraddr1;
  logic [PW-1:0] md1, sd1, wrdata1;

  logic [PW-1:0] main_mem [0:31];
  logic [PW-1:0] sc_mem   [0:31];
  logic [PW-1:0] wlog0    [0:31];
  logic [PW-1:0] wlog1    [0:31];

  logic [AW+PW-1:0] q0 [$];
  logic [AW+PW-1:0] q1 [$];

  int errors = 0;
  int checks = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int en_cyc = 0;
  int last_wr0 = -10;
  int last_wr1 = -10;

  always #5 clk = ~clk;

  residual_fusion_unit #(.SHIFT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en),
    .i_start(start), .i_relu_en(relu_en),
    .o_busy(busy0), .o_done(done0),
    .o_main_rd_addr(maddr0), .i_main_rd_data_flat(md0),
    .o_sc_rd_en(scen0), .o_sc_rd_addr(scaddr0),
    .i_sc_rd_data_flat(sd0),
    .o_out_wr_en(wren0), .o_out_wr_addr(wraddr0),
    .o_out_wr_data_flat(wrdata0)
  );

  residual_fusion_unit #(.SHIFT(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_clk_en(clk_en),
    .i_start(start), .i_relu_en(relu_en),
    .o_busy(busy1), .o_done(done1),
    .o_main_rd_addr(maddr1), .i_main_rd_data_flat(md1),
    .o_sc_rd_en(scen1), .o_sc_rd_addr(scaddr1),
    .i_sc_rd_data_flat(sd1),
    .o_out_wr_en(wren1), .o_out_wr_addr(wraddr1),
    .o_out_wr_data_flat(wrdata1)
  );

  // BRAM models, one-cycle latency, gated by the global enable
  always @(posedge clk) begin
    if (clk_en) begin
      md0 <= main_mem[maddr0[4:0]];
      md1 <= main_mem[maddr1[4:0]];
      if (scen0) sd0 <= sc_mem[scaddr0[4:0]];
      if (scen1) sd1 <= sc_mem[scaddr1[4:0]];
    end
  end

  function automatic logic [7:0] fuse(
    input logic [7:0] a, input logic [7:0] b,
    input int sh, input bit relu);
    int s;
    s = $signed(a) + $signed(b);
    if (sh > 0) s = (s + (1 << (sh - 1))) >>> sh;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  function automatic logic [PW-1:0] fuse_px(
    input logic [PW-1:0] m, input logic [PW-1:0] s,
    input int sh, input bit relu);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[i*8 +: 8] = fuse(m[i*8 +: 8], s[i*8 +: 8], sh, relu);
    return r;
  endfunction

  // Monitor: pop scoreboard on each enabled write, time o_done
  always @(negedge clk) begin
    if (rst_n && clk_en) begin
      if (wren0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL wr0_extra addr=%0d", wraddr0);
        end else begin
          logic [AW+PW-1:0] e;
          e = q0.pop_front();
          if ({wraddr0, wrdata0} !== e) begin
            errors++;
            $display("FAIL wr0 got a=%0d d=%h want a=%0d d=%h",
              wraddr0, wrdata0, e[AW+PW-1:PW], e[PW-1:0]);
          end
        end
        wlog0[wraddr0[4:0]] = wrdata0;
        last_wr0 = en_cyc;
      end
      if (wren1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL wr1_extra addr=%0d", wraddr1);
        end else begin
          logic [AW+PW-1:0] e;
          e = q1.pop_front();
          if ({wraddr1, wrdata1} !== e) begin
            errors++;
            $display("FAIL wr1 got a=%0d d=%h want a=%0d d=%h",
              wraddr1, wrdata1, e[AW+PW-1:PW], e[PW-1:0]);
          end
        end
        wlog1[wraddr1[4:0]] = wrdata1;
        last_wr1 = en_cyc;
      end
      if (done0) begin
        done_cnt0++;
        checks++;
        if (last_wr0 + 1 != en_cyc || q0.size() != 0) begin
          errors++;
          $display("FAIL done0_timing got cyc=%0d want %0d left=%0d",
            en_cyc, last_wr0 + 1, q0.size());
        end
      end
      if (done1) begin
        done_cnt1++;
        checks++;
        if (last_wr1 + 1 != en_cyc || q1.size() != 0) begin
          errors++;
          $display("FAIL done1_timing got cyc=%0d want %0d left=%0d",
            en_cyc, last_wr1 + 1, q1.size());
        end
      end
      en_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] m, input logic [7:0] s);
    for (int p = 0; p < 32; p++) begin
      main_mem[p] = {8{m}};
      sc_mem[p]   = {8{s}};
    end
  endtask

  task automatic push_exp(input bit relu);
    for (int p = 0; p < N; p++) begin
      q0.push_back({AW'(p), fuse_px(main_mem[p], sc_mem[p], 1, relu)});
      q1.push_back({AW'(p), fuse_px(main_mem[p], sc_mem[p], 0, relu)});
    end
  endtask

  task automatic do_run(input bit relu, input bit stall,
                        input bit toggle, input bit extra);
    int d0;
    int d1;
    d0 = done_cnt0;
    d1 = done_cnt1;
    push_exp(relu);
    relu_en = relu;
    clk_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %b%b want 11", busy0, busy1);
    end
    for (int c = 0; c < 400; c++) begin
      if (done_cnt0 != d0 && done_cnt1 != d1) break;
      clk_en = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (toggle && c == 5) relu_en = ~relu;
      start = (extra && c == 8) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    clk_en = 1'b1;
    tick();
    tick();
    checks++;
    if (done_cnt0 != d0 + 1 || done_cnt1 != d1 + 1) begin
      errors++;
      $display("FAIL done_count got %0d/%0d want 1/1",
        done_cnt0 - d0, done_cnt1 - d1);
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL writes_missing got left %0d/%0d want 0/0",
        q0.size(), q1.size());
    end
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done got %b%b want 00", busy0, busy1);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({busy0, done0, maddr0, scen0, scaddr0, wren0, wraddr0,
         wrdata0, busy1, done1, maddr1, scen1, scaddr1, wren1,
         wraddr1, wrdata1} !== '0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b a=%0d en=%b we=%b wd=%h want all 0",
        nm, busy0, done0, maddr0, scen0, wren0, wrdata0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    check_zero("reset_state");
    tick();
    rst_n = 1'b1;
    tick();
    check_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    fill(8'd10, 8'd20);
    do_run(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wlog0[19] !== {8{8'd15}} || wlog1[0] !== {8{8'd30}}) begin
      errors++;
      $display("FAIL basic_value got %h/%h want 0f../1e..",
        wlog0[19], wlog1[0]);
    end
  endtask

  task automatic test_saturate();
    for (int p = 0; p < 32; p++) begin
      main_mem[p] = {$urandom, $urandom};
      sc_mem[p]   = {$urandom, $urandom};
    end
    main_mem[0][23:0] = {8'd100, 8'h80, 8'd127};
    sc_mem[0][23:0]   = {8'hE2, 8'h80, 8'd127};
    do_run(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wlog1[0][23:0] !== {8'd70, 8'h80, 8'h7F}) begin
      errors++;
      $display("FAIL saturate got %h want 46807f", wlog1[0][23:0]);
    end
  endtask

  task automatic test_rounding();
    fill(8'd0, 8'd0);
    main_mem[1][31:0] = {8'd0, 8'hFE, 8'hFF, 8'd1};
    sc_mem[1][31:0]   = {8'd1, 8'hFE, 8'hFE, 8'd2};
    do_run(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wlog0[1][31:0] !== {8'd1, 8'hFE, 8'hFF, 8'd2}) begin
      errors++;
      $display("FAIL rounding got %h want 01feff02", wlog0[1][31:0]);
    end
  endtask

  task automatic test_relu();
    fill(8'hCE, 8'd10);
    main_mem[1] = {8{8'd40}};
    do_run(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (wlog0[0] !== '0 || wlog1[15] !== '0 || wlog0[19] !== '0) begin
      errors++;
      $display("FAIL relu_neg got %h/%h want 0", wlog0[0], wlog1[15]);
    end
    checks++;
    if (wlog0[1] !== {8{8'd25}}) begin
      errors++;
      $display("FAIL relu_pos got %h want 19..", wlog0[1]);
    end
  endtask

  task automatic test_stall();
    fill(8'd10, 8'd20);
    do_run(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt0;
    fill(8'd10, 8'd20);
    push_exp(1'b0);
    relu_en = 1'b0;
    clk_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (scen0 && maddr0 == AW'(6)) break;
      tick();
    end
    checks++;
    if (!(scen0 && maddr0 == AW'(6))) begin
      errors++;
      $display("FAIL addr6_wait got a=%0d en=%b want 6/1", maddr0, scen0);
    end
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_run");
    tick();
    tick();
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) tick();
    checks++;
    if (done_cnt0 != d0 || wren0 !== 1'b0) begin
      errors++;
      $display("FAIL no_done_after_abort got %0d want 0", done_cnt0 - d0);
    end
    do_run(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_rounding();
    test_relu();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
